// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WRITE,
    S_RESP
  } state_e;

  function automatic int tag_w(int aw, int ls, int lb);
    return aw - ls - lb;
  endfunction

  function automatic int idx_w(int ls);
    return ls;
  endfunction

  // word-offset width; a one-word line still keeps a 1-bit field
  function automatic int woff_w(int lb);
    return (lb > 2) ? lb - 2 : 1;
  endfunction

  function automatic int way_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/setassoc_cache_if.sv
// CPU load/store port and word-wide memory bus of the cache.
interface setassoc_cache_cpu_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_ready;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_we;
  logic [31:0]       cpu_wdata;
  logic              cpu_done;
  logic [31:0]       cpu_rdata;

  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_wdata,
    input  cpu_ready, cpu_done, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
    output cpu_ready, cpu_done, cpu_rdata
  );
endinterface

interface setassoc_cache_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cache_way.sv
// One cache way: valid/tag/data arrays with a combinational
// read port and tag compare for the addressed set.
module cache_way #(
  parameter int LS    = 7,
  parameter int OW    = 3,
  parameter int WORDS = 8,
  parameter int TW    = 20
) (
  input  logic          clk,
  input  logic [LS-1:0] idx,
  input  logic [OW-1:0] woff,
  input  logic [TW-1:0] tag,
  output logic          hit,
  output logic          vld,
  output logic [31:0]   rdata,
  input  logic          inv,
  input  logic [LS-1:0] inv_idx,
  input  logic          dwe,
  input  logic [OW-1:0] dwoff,
  input  logic [31:0]   dwdata,
  input  logic          twe
);
  localparam int SETS = 1 << LS;

  logic          valid [SETS];
  logic [TW-1:0] tags  [SETS];
  logic [31:0]   data  [SETS][WORDS];

  assign vld   = valid[idx];
  assign hit   = vld && (tags[idx] == tag);
  assign rdata = data[idx][woff];

  always_ff @(posedge clk) begin
    if (twe) begin
      valid[idx] <= 1'b1;
      tags[idx]  <= tag;
    end else if (inv) begin
      valid[inv_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (dwe) data[idx][dwoff] <= dwdata;
  end

endmodule

// File: rtl/setassoc_cache.sv
// N-way set-associative write-through, no-write-allocate cache
// with line refill, round-robin victims and a reset sweep.
module setassoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W             = 32,
  parameter int LOG_BYTES_PER_LINE = 5,
  parameter int LOG_NUM_SETS       = 7,
  parameter int NUM_WAYS           = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  setassoc_cache_cpu_if.slave       cpu,
  setassoc_cache_mem_if.master      mem
);
  localparam int LB    = LOG_BYTES_PER_LINE;
  localparam int LS    = idx_w(LOG_NUM_SETS);
  localparam int SETS  = 1 << LS;
  localparam int WORDS = 1 << (LB - 2);
  localparam int TW    = tag_w(ADDR_W, LS, LB);
  localparam int OW    = woff_w(LB);
  localparam int WW    = way_w(NUM_WAYS);
  localparam int AW2   = ADDR_W - 2;

  state_e state, nxt;

  logic [AW2-1:0] waddr_q;
  logic           we_q;
  logic [31:0]    wdata_q;
  logic [31:0]    rdata_q;
  logic [LS-1:0]  icnt;
  logic [OW-1:0]  wcnt;
  logic [WW-1:0]  vic_q;
  logic [WW-1:0]  hway_q;
  logic           hit_q;
  logic [WW-1:0]  rr [SETS];

  logic [NUM_WAYS-1:0] hit;
  logic [NUM_WAYS-1:0] vld;
  logic [31:0]         rd [NUM_WAYS];

  logic [LS-1:0]  idx;
  logic [TW-1:0]  tag;
  logic [OW-1:0]  woff;
  logic [AW2-1:0] line_w;
  logic           any_hit;
  logic [WW-1:0]  hway;
  logic [WW-1:0]  vic;
  logic           ack;
  logic           last;
  logic           fill_done;
  logic           inv_all;
  logic           inv_vic;
  logic [LS-1:0]  inv_idx;
  logic [OW-1:0]  dwoff;
  logic [31:0]    dwdata;
  logic           unused_addr;

  assign unused_addr = ^cpu.cpu_addr[1:0];

  assign idx    = waddr_q[LB-2 +: LS];
  assign tag    = waddr_q[AW2-1 -: TW];
  assign woff   = OW'(waddr_q & AW2'(WORDS - 1));
  assign line_w = waddr_q & ~AW2'(WORDS - 1);

  assign ack       = mem.mem_ack;
  assign last      = (wcnt == OW'(WORDS - 1));
  assign fill_done = (state == S_REFILL) && ack && last;

  assign inv_all = (state == S_INIT);
  assign inv_vic = (state == S_LOOKUP) && !we_q && !any_hit;
  assign inv_idx = inv_all ? icnt : idx;
  assign dwoff   = (state == S_REFILL) ? wcnt : woff;
  assign dwdata  = (state == S_REFILL) ? mem.mem_rdata : wdata_q;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic dwe;
    assign dwe = !rst && ack && (
      ((state == S_REFILL) && (vic_q == WW'(w))) ||
      ((state == S_WRITE) && hit_q && (hway_q == WW'(w))));

    cache_way #(
      .LS(LS), .OW(OW), .WORDS(WORDS), .TW(TW)
    ) u_way (
      .clk    (clk),
      .idx    (idx),
      .woff   (woff),
      .tag    (tag),
      .hit    (hit[w]),
      .vld    (vld[w]),
      .rdata  (rd[w]),
      .inv    (inv_all | (inv_vic && (vic == WW'(w)))),
      .inv_idx(inv_idx),
      .dwe    (dwe),
      .dwoff  (dwoff),
      .dwdata (dwdata),
      .twe    (fill_done && !rst && (vic_q == WW'(w)))
    );
  end

  // lowest-index hit / lowest-index invalid way wins
  always_comb begin
    any_hit = |hit;
    hway    = '0;
    vic     = rr[idx];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (hit[w]) hway = WW'(w);
      if (!vld[w]) vic = WW'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_INIT:   if (icnt == LS'(SETS - 1)) nxt = S_IDLE;
      S_IDLE:   if (cpu.cpu_req) nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (we_q)         nxt = S_WRITE;
        else if (any_hit) nxt = S_RESP;
        else              nxt = S_REFILL;
      end
      S_REFILL: if (ack && last) nxt = S_RESP;
      S_WRITE:  if (ack) nxt = S_RESP;
      S_RESP:   nxt = S_IDLE;
      default:  nxt = S_INIT;
    endcase
  end

  always_comb begin
    cpu.cpu_ready = 1'b0;
    cpu.cpu_done  = 1'b0;
    cpu.cpu_rdata = '0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    unique case (1'b1)
      (state == S_IDLE): cpu.cpu_ready = 1'b1;
      (state == S_RESP): begin
        cpu.cpu_done  = 1'b1;
        cpu.cpu_rdata = we_q ? 32'h0 : rdata_q;
      end
      (state == S_REFILL): begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = {line_w | AW2'(wcnt), 2'b00};
      end
      (state == S_WRITE): begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {waddr_q, 2'b00};
        mem.mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      icnt    <= '0;
      wcnt    <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      vic_q   <= '0;
      hway_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (state == S_INIT) icnt <= icnt + 1'b1;
      if (state == S_IDLE && cpu.cpu_req) begin
        waddr_q <= cpu.cpu_addr[ADDR_W-1:2];
        we_q    <= cpu.cpu_we;
        wdata_q <= cpu.cpu_wdata;
      end
      if (state == S_LOOKUP) begin
        hit_q   <= any_hit;
        hway_q  <= hway;
        vic_q   <= vic;
        rdata_q <= rd[hway];
        wcnt    <= '0;
      end
      if (state == S_REFILL && ack) begin
        wcnt <= last ? '0 : wcnt + 1'b1;
        if (wcnt == woff) rdata_q <= mem.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      rr[icnt] <= '0;
    end else if (!rst && fill_done) begin
      rr[idx] <= (rr[idx] == WW'(NUM_WAYS - 1)) ? '0
                                                : rr[idx] + 1'b1;
    end
  end

endmodule

// File: tb/tb_setassoc_cache.sv
// Randomised and directed bench for setassoc_cache against a
// transaction-level cache model and a backing memory.
module tb_setassoc_cache;
  localparam int AW    = 32;
  localparam int NW    = 2;
  localparam int SETS  = 128;
  localparam int WORDS = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  setassoc_cache_cpu_if #(.ADDR_W(AW)) cpu_bus ();
  setassoc_cache_mem_if #(.ADDR_W(AW)) mem_bus ();

  setassoc_cache #(
    .ADDR_W(AW), .LOG_BYTES_PER_LINE(5),
    .LOG_NUM_SETS(7), .NUM_WAYS(NW)
  ) dut (
    .clk(clk), .rst(rst), .cpu(cpu_bus), .mem(mem_bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          hit;
    bit          rd;
    logic [31:0] data;
    int          acc;
  } rsp_t;

  txn_t exp_mem[$];
  rsp_t exp_rsp[$];

  logic [31:0] mstore [logic [31:0]];
  logic [19:0] mtag [SETS][NW];
  bit          mval [SETS][NW];
  int          mrr  [SETS];

  int          n_mem = 0, n_done = 0, acks_total = 0;
  int          last_ack_cyc = 0, done_cyc = 0;
  logic [31:0] done_data = '0;
  bit          mem_rand = 0, mem_hold = 0;
  int          stall_at = -1, started = 0;

  function automatic logic [31:0] mword(logic [31:0] a);
    return mstore.exists(a) ? mstore[a] : a;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic void model_reset();
    foreach (mval[s, w]) mval[s][w] = 0;
    foreach (mrr[s]) mrr[s] = 0;
    exp_mem.delete();
    exp_rsp.delete();
  endfunction

  // memory: word = address unless written; optional random wait
  initial begin
    bit pend;
    int wl;
    pend = 0;
    wl = 0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_bus.mem_ack = 1'b0;
      if (!mem_bus.mem_req || mem_hold) begin
        pend = 0;
      end else begin
        if (!pend) begin
          pend = 1;
          wl = mem_rand ? int'($urandom_range(0, 3)) : 0;
          if (started == stall_at) wl = 10;
          started++;
        end
        if (wl == 0) begin
          pend = 0;
          acks_total++;
          mem_bus.mem_ack = 1'b1;
          if (mem_bus.mem_we)
            mstore[mem_bus.mem_addr] = mem_bus.mem_wdata;
          mem_bus.mem_rdata = mword(mem_bus.mem_addr);
        end else begin
          wl--;
        end
      end
    end
  end

  // compare process
  initial begin
    logic        p_req, p_ack, p_we;
    logic [31:0] p_addr, p_wd;
    txn_t        e;
    rsp_t        r;
    p_req = 0;
    p_ack = 0;
    p_we = 0;
    p_addr = '0;
    p_wd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst && exp_mem.size() == 0)
        check("mem_req_unexpected", mem_bus.mem_req, 1'b0);
      if (!rst && p_req && !p_ack && mem_bus.mem_req) begin
        check("stable_addr", mem_bus.mem_addr, p_addr);
        check("stable_we", mem_bus.mem_we, p_we);
        check("stable_wdata", mem_bus.mem_wdata, p_wd);
      end
      if (mem_bus.mem_req && mem_bus.mem_ack &&
          exp_mem.size() != 0) begin
        n_mem++;
        last_ack_cyc = cyc;
        e = exp_mem.pop_front();
        check("mem_we", mem_bus.mem_we, e.we);
        check("mem_addr", mem_bus.mem_addr, e.addr);
        if (e.we) check("mem_wdata", mem_bus.mem_wdata, e.wdata);
      end
      if (exp_rsp.size() == 0) begin
        if (!rst) check("done_unexpected", cpu_bus.cpu_done, 1'b0);
      end else if (cpu_bus.cpu_done) begin
        n_done++;
        done_cyc  = cyc;
        done_data = cpu_bus.cpu_rdata;
        r = exp_rsp.pop_front();
        if (r.rd) check("rdata", cpu_bus.cpu_rdata, r.data);
        if (r.hit) begin
          check("hit_latency", cyc - r.acc, 2);
        end else begin
          check("done_after_ack", cyc - last_ack_cyc, 1);
          check("mem_outstanding", exp_mem.size(), 0);
        end
      end
      p_req  = mem_bus.mem_req;
      p_ack  = mem_bus.mem_ack;
      p_we   = mem_bus.mem_we;
      p_addr = mem_bus.mem_addr;
      p_wd   = mem_bus.mem_wdata;
    end
  end

  // caller sits at posedge+1; leaves at posedge+1 of the LOOKUP cycle
  task automatic issue(input logic [31:0] a, input bit we,
                       input logic [31:0] wd, output int acc);
    int          s, v, w8;
    logic [19:0] t;
    bit          hit;
    rsp_t        r;
    w8 = 0;
    while (!cpu_bus.cpu_ready && w8 < 400) begin
      @(posedge clk);
      #1;
      w8++;
    end
    check("ready_wait", cpu_bus.cpu_ready, 1'b1);
    s = int'(a[11:5]);
    t = a[31:12];
    hit = 0;
    for (int w = 0; w < NW; w++)
      if (mval[s][w] && mtag[s][w] == t) hit = 1;
    acc    = cyc + 1;
    r.acc  = acc;
    r.rd   = !we;
    r.hit  = hit && !we;
    r.data = mword({a[31:2], 2'b00});
    if (we) begin
      exp_mem.push_back('{1'b1, {a[31:2], 2'b00}, wd});
    end else if (!hit) begin
      v = -1;
      for (int w = 0; w < NW; w++)
        if (!mval[s][w] && v < 0) v = w;
      if (v < 0) v = mrr[s];
      for (int i = 0; i < WORDS; i++)
        exp_mem.push_back('{1'b0, {a[31:5], 5'b0} + 32'(4 * i), 32'h0});
      mval[s][v] = 1;
      mtag[s][v] = t;
      mrr[s] = (mrr[s] + 1) % NW;
    end
    exp_rsp.push_back(r);
    cpu_bus.cpu_req   = 1'b1;
    cpu_bus.cpu_addr  = a;
    cpu_bus.cpu_we    = we;
    cpu_bus.cpu_wdata = wd;
    @(posedge clk);
    #1;
    cpu_bus.cpu_req = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input bit we,
                        input logic [31:0] wd, output int ntx,
                        output int lat, output logic [31:0] rd);
    int acc, n0, d0, w8;
    n0 = n_mem;
    d0 = n_done;
    issue(a, we, wd, acc);
    w8 = 0;
    while (n_done == d0 && w8 < 400) begin
      @(posedge clk);
      #1;
      w8++;
    end
    check("done_seen", 32'(n_done - d0), 1);
    if (n_done == d0) begin
      exp_mem.delete();
      exp_rsp.delete();
    end
    ntx = n_mem - n0;
    lat = done_cyc - acc;
    rd  = done_data;
  endtask

  // caller at posedge+1 with the cycle to carry rst
  task automatic do_reset();
    int n;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", cpu_bus.cpu_ready, 1'b0);
    check("rst_done", cpu_bus.cpu_done, 1'b0);
    check("rst_mem_req", mem_bus.mem_req, 1'b0);
    check("rst_mem_we", mem_bus.mem_we, 1'b0);
    check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
    check("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
    check("rst_rdata", cpu_bus.cpu_rdata, 32'h0);
    model_reset();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cpu_bus.cpu_ready) break;
      n++;
    end
    check("sweep_cycles", n, 128);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ntx, lat, acc, b, w8;
    logic [31:0] rd, a;
    bit          we;
    cpu_bus.cpu_req   = 1'b0;
    cpu_bus.cpu_addr  = '0;
    cpu_bus.cpu_we    = 1'b0;
    cpu_bus.cpu_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    do_req(32'h1004, 0, 0, ntx, lat, rd);
    check("cold_ntx", ntx, 8);
    check("cold_rdata", rd, 32'h1004);
    check("cold_lat", lat, 10);
    do_req(32'h1004, 0, 0, ntx, lat, rd);
    check("warm_ntx", ntx, 0);
    check("warm_lat", lat, 2);
    check("warm_rdata", rd, 32'h1004);

    do_req(32'h1000, 0, 0, ntx, lat, rd);
    check("r1000_hit", ntx, 0);
    do_req(32'h2000, 0, 0, ntx, lat, rd);
    check("r2000_miss", ntx, 8);
    do_req(32'h3000, 0, 0, ntx, lat, rd);
    check("r3000_miss", ntx, 8);
    do_req(32'h2000, 0, 0, ntx, lat, rd);
    check("r2000_rehit", ntx, 0);
    do_req(32'h1000, 0, 0, ntx, lat, rd);
    check("r1000_evicted", ntx, 8);

    do_req(32'h1004, 1, 32'hDEADBEEF, ntx, lat, rd);
    check("wr_hit_ntx", ntx, 1);
    do_req(32'h1004, 0, 0, ntx, lat, rd);
    check("wr_hit_rd_ntx", ntx, 0);
    check("wr_hit_rdata", rd, 32'hDEADBEEF);
    do_req(32'h5000, 1, 32'h12345678, ntx, lat, rd);
    check("wr_miss_ntx", ntx, 1);
    do_req(32'h5000, 0, 0, ntx, lat, rd);
    check("wr_miss_rd_ntx", ntx, 8);
    check("wr_miss_rdata", rd, 32'h12345678);

    stall_at = started + 3;
    do_req(32'h7004, 0, 0, ntx, lat, rd);
    check("stall_lat", lat, 20);
    check("stall_ntx", ntx, 8);
    check("stall_rdata", rd, 32'h7004);
    stall_at = -1;

    do_reset();
    b = acks_total;
    issue(32'h1000, 0, 0, acc);
    w8 = 0;
    while (acks_total < b + 3 && w8 < 100) begin
      @(posedge clk);
      #2;
      w8++;
    end
    check("mid_acks", acks_total - b, 3);
    mem_hold = 1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_mem_req", mem_bus.mem_req, 1'b0);
    mem_hold = 0;
    do_reset();
    do_req(32'h1000, 0, 0, ntx, lat, rd);
    check("post_abort_miss", ntx, 8);
    check("post_abort_rdata", rd, 32'h1000);

    mem_rand = 1;
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(1, 6)) << 12) |
          (32'($urandom_range(0, 3)) << 5) |
          (32'($urandom_range(0, 7)) << 2) |
          32'($urandom_range(0, 3));
      we = ($urandom_range(0, 9) < 3);
      do_req(a, we, $urandom, ntx, lat, rd);
    end
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
